// File: rtl/board_pkg.sv
// Shared types and win-line table for the tic-tac-toe board engine.
package board_pkg;

   typedef enum logic [1:0] {EMPTY = 2'b00, P1 = 2'b01, P2 = 2'b10} cell_t;

   localparam int BOARD_CELLS = 9;
   localparam int NUM_LINES   = 8;

   // Indexed as WIN_LINES[line][k]; line 0 is the last entry of the concatenation.
   localparam logic [7:0][2:0][3:0] WIN_LINES = {
      {4'd6, 4'd4, 4'd2},
      {4'd8, 4'd4, 4'd0},
      {4'd8, 4'd5, 4'd2},
      {4'd7, 4'd4, 4'd1},
      {4'd6, 4'd3, 4'd0},
      {4'd8, 4'd7, 4'd6},
      {4'd5, 4'd4, 4'd3},
      {4'd2, 4'd1, 4'd0}
   };

   function automatic logic [1:0] line_owner(input logic [17:0] board, input logic [2:0] line);
      logic [4:0] baseA;
      logic [4:0] baseB;
      logic [4:0] baseC;
      logic [1:0] a;
      logic [1:0] b;
      logic [1:0] c;
      baseA = {WIN_LINES[line][0], 1'b0};
      baseB = {WIN_LINES[line][1], 1'b0};
      baseC = {WIN_LINES[line][2], 1'b0};
      a = board[baseA +: 2];
      b = board[baseB +: 2];
      c = board[baseC +: 2];
      return ((a != EMPTY) && (a == b) && (b == c)) ? a : EMPTY;
   endfunction

endpackage

// File: rtl/board_engine_if.sv
// Strobe/status bundle between the game controller (master) and the board engine (slave).
interface board_engine_if;
   import board_pkg::*;

   logic        set_first_player;
   logic        player_one_first;
   logic        create_board;
   logic        check_player_move;
   logic [3:0]  move_idx;
   logic        make_random_move;
   logic        make_player_move;
   logic        change_turn;
   logic        valid_move;
   logic        winner;
   logic [1:0]  winner_id;
   logic        full_board;
   logic        current_player;
   logic [17:0] board;
   logic [3:0]  move_count;
   logic        rand_none;

   modport master (
      output set_first_player, player_one_first, create_board, check_player_move,
             move_idx, make_random_move, make_player_move, change_turn,
      input  valid_move, winner, winner_id, full_board, current_player, board,
             move_count, rand_none
   );

   modport slave (
      input  set_first_player, player_one_first, create_board, check_player_move,
             move_idx, make_random_move, make_player_move, change_turn,
      output valid_move, winner, winner_id, full_board, current_player, board,
             move_count, rand_none
   );

endinterface

// File: rtl/board_rand_pick.sv
// Cyclic priority search: first set bit of the empty mask at or after i_start, wrapping 8->0.
module board_rand_pick
   import board_pkg::*;
(
   input  logic [3:0] i_start,
   input  logic [8:0] i_emptyMask,
   output logic       o_found,
   output logic [3:0] o_idx
);

   always_comb begin
      logic [4:0] w_cand;
      o_found = 1'b0;
      o_idx   = 4'd0;
      w_cand  = 5'd0;
      for (int k = 0; k < BOARD_CELLS; k++) begin
         w_cand = 5'(i_start) + 5'(k);
         if (w_cand >= 5'(BOARD_CELLS)) begin
            w_cand = w_cand - 5'(BOARD_CELLS);
         end
         if (!o_found && i_emptyMask[w_cand[3:0]]) begin
            o_found = 1'b1;
            o_idx   = w_cand[3:0];
         end
      end
   end

endmodule

// File: rtl/board_engine.sv
// 3x3 board storage, move legality, win/full detection, turn tracking and random fallback pick.
module board_engine
   import board_pkg::*;
#(
   parameter int RAND_SEED   = 0,
   parameter bit P1_AT_RESET = 1'b1
)
(
   input  logic           clk,
   input  logic           rst,
   board_engine_if.slave  bus
);

   logic [17:0] r_board;
   logic [3:0]  r_moveCount;
   logic [3:0]  r_pendingIdx;
   logic [3:0]  r_randCtr;
   logic        r_randNone;
   logic        r_currentPlayer;

   logic [8:0]  w_emptyMask;
   logic [15:0] w_emptyWide;
   logic        w_pickFound;
   logic [3:0]  w_pickIdx;
   logic        w_pendingOk;
   logic [4:0]  w_cellBase;
   logic [1:0]  w_winnerId;

   always_comb begin
      w_emptyMask = '0;
      for (int i = 0; i < BOARD_CELLS; i++) begin
         w_emptyMask[i] = (r_board[2*i +: 2] == EMPTY);
      end
   end

   // Zero-extended so out-of-range indices 9..15 read as occupied.
   assign w_emptyWide = {7'd0, w_emptyMask};
   assign w_pendingOk = (r_pendingIdx < 4'(BOARD_CELLS)) && w_emptyWide[r_pendingIdx];
   assign w_cellBase  = {r_pendingIdx, 1'b0};

   board_rand_pick u_randPick (
      .i_start     (r_randCtr),
      .i_emptyMask (w_emptyMask),
      .o_found     (w_pickFound),
      .o_idx       (w_pickIdx)
   );

   always_comb begin
      w_winnerId = EMPTY;
      for (int l = 0; l < NUM_LINES; l++) begin
         if (w_winnerId == EMPTY) begin
            w_winnerId = line_owner(r_board, 3'(l));
         end
      end
   end

   assign bus.valid_move     = (bus.move_idx < 4'(BOARD_CELLS)) && w_emptyWide[bus.move_idx];
   assign bus.winner         = (w_winnerId != EMPTY);
   assign bus.winner_id      = w_winnerId;
   assign bus.full_board     = (r_moveCount == 4'(BOARD_CELLS));
   assign bus.current_player = r_currentPlayer;
   assign bus.board          = r_board;
   assign bus.move_count     = r_moveCount;
   assign bus.rand_none      = r_randNone;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_randCtr <= 4'(RAND_SEED);
      end else if (r_randCtr == 4'(BOARD_CELLS - 1)) begin
         r_randCtr <= 4'd0;
      end else begin
         r_randCtr <= r_randCtr + 4'd1;
      end
   end

   // A write always targets the pending cell latched in an earlier cycle.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_board      <= '0;
         r_moveCount  <= 4'd0;
         r_pendingIdx <= 4'd0;
         r_randNone   <= 1'b0;
      end else if (bus.create_board) begin
         r_board      <= '0;
         r_moveCount  <= 4'd0;
         r_pendingIdx <= 4'd0;
         r_randNone   <= 1'b0;
      end else begin
         if (bus.make_random_move) begin
            if (w_pickFound) begin
               r_pendingIdx <= w_pickIdx;
               r_randNone   <= 1'b0;
            end else begin
               r_randNone   <= 1'b1;
            end
         end else if (bus.check_player_move) begin
            r_pendingIdx <= bus.move_idx;
         end
         if (bus.make_player_move && w_pendingOk) begin
            r_board[w_cellBase +: 2] <= {r_currentPlayer, ~r_currentPlayer};
            if (r_moveCount < 4'(BOARD_CELLS)) begin
               r_moveCount <= r_moveCount + 4'd1;
            end
         end
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_currentPlayer <= ~P1_AT_RESET;
      end else if (bus.set_first_player) begin
         r_currentPlayer <= ~bus.player_one_first;
      end else if (bus.change_turn) begin
         r_currentPlayer <= ~r_currentPlayer;
      end
   end

endmodule

// File: doc/board_engine.md
Name: board_engine

Overview:
- Holds the 3x3 tic-tac-toe board and serves the game controller.
- Consumes the controller's one-hot state strobes: first-player select, create board, check move, random move, make move, change turn.
- Returns valid_move, winner and full_board, combinationally, in the same cycle the controller samples them.
- Also tracks the current player and picks the random fallback move on timeout.

Parameters:
- RAND_SEED, 0, reset value of the 0..8 random-cell counter.
- P1_AT_RESET, 1, 1 = player one is current_player out of reset.

Ports:
- clk  in  1  system clock
- rst  in  1  reset; one clock; reset is asynchronous and active-low
- set_first_player  in  1  strobe: load current_player from player_one_first
- player_one_first  in  1  1 = player one starts, 0 = player two starts
- create_board  in  1  strobe: clear board and move count
- check_player_move  in  1  strobe: latch move_idx as the pending cell
- move_idx  in  4  cell chosen by the player; legal values 0..8
- make_random_move  in  1  strobe: latch an auto-picked empty cell as the pending cell
- make_player_move  in  1  strobe: write the pending cell with current_player
- change_turn  in  1  strobe: toggle current_player
- valid_move  out  1  combinational: move_idx<9 and that cell is empty
- winner  out  1  combinational: some line holds three equal non-empty cells
- winner_id  out  2  owner of the winning line; 00 if winner=0
- full_board  out  1  combinational: all 9 cells occupied
- current_player  out  1  0 = player one, 1 = player two
- board  out  18  cell i at bits [2i+1:2i]; 00 empty, 01 P1, 10 P2
- move_count  out  4  number of occupied cells, 0..9
- rand_none  out  1  registered: last random pick found no empty cell

Behaviour:
Reset (rst low, async):
- board=0, move_count=0, pending_idx=0, rand_none=0.
- current_player = ~P1_AT_RESET.
- rand_ctr = RAND_SEED.

Random counter:
- rand_ctr increments every clock and wraps 8->0.
- It never stops, including during other strobes.

Strobe priority, highest first:
- create_board > set_first_player > check_player_move / make_random_move > make_player_move > change_turn.
- Non-conflicting strobes in the same cycle all take effect.
- create_board: board=0, move_count=0, rand_none=0, pending_idx=0. Any write or pick strobe in the same cycle is ignored.
- set_first_player: current_player = player_one_first ? 0 : 1. Overrides a same-cycle change_turn.
- check_player_move: pending_idx <= move_idx, latched even if invalid. valid_move is purely combinational from move_idx and the registered board; there is no latency.
- make_random_move:
  - Scans cells cyclically from rand_ctr (rand_ctr, rand_ctr+1 mod 9, ...).
  - The first empty cell goes into pending_idx, rand_none <= 0.
  - If no cell is empty: pending_idx unchanged, rand_none <= 1.
  - If check_player_move is also asserted, make_random_move wins.
- make_player_move:
  - If pending_idx<9 and that cell is empty: cell <= current_player+1, move_count+1.
  - Otherwise: no write, no count change.
  - The new board is visible on outputs the next cycle.
- change_turn: current_player <= ~current_player.
  - If asserted together with make_player_move, the write uses the pre-toggle player.

Combinational outputs:
- winner / winner_id evaluate the 8 lines in order: rows 0-2, columns 0-2, diagonal 0-4-8, anti-diagonal 2-4-6.
- The first matching line supplies winner_id.
- full_board = (move_count==9), which must equal "no empty cell".
- move_count saturates at 9.

Boundary cases:
- move_idx 9..15: valid_move=0.
- Reset mid-game clears everything immediately, independent of clk.

Decomposition:
- Package board_pkg:
  - cell_t enum {EMPTY=2'b00, P1=2'b01, P2=2'b10}.
  - BOARD_CELLS=9.
  - WIN_LINES constant: 8x3 cell indices.
  - function line_owner(board, line).
- Sub-module board_rand_pick: combinational cyclic priority search, start index plus 9-bit empty mask in, found flag plus 4-bit index out. It is shared logic worth isolating for unit test.

Test Plan:
1. Reset, set_first_player with player_one_first=1, create_board -> board=0, current_player=0, move_count=0, winner=0, full_board=0.
2. move_idx=4, check_player_move -> valid_move=1 same cycle. Then make_player_move -> board[9:8]=01, move_count=1. Then move_idx=4 again -> valid_move=0. move_idx=12 -> valid_move=0.
3. P1 at 0, 1, 2 with change_turn between turns and P2 at 3, 4 -> after the last write, winner=1, winner_id=01.
4. Cells 0..7 filled, rand_ctr=3, make_random_move then make_player_move -> pending_idx=8, cell 8 written, full_board=1, move_count=9. A further make_random_move -> rand_none=1, board unchanged.
5. make_player_move and change_turn in the same cycle with current_player=1 -> cell written 10, current_player=0 next cycle. create_board together with make_player_move -> board=0, no write.
6. Drop rst mid-game, asynchronously between clock edges -> all outputs at reset values before the next clk edge. rand_ctr=RAND_SEED on release.
